// File: rtl/lfsr_pkg.sv
// Shared LFSR step/advance functions and the stream FSM encoding for the PRBS generator.
// Vectors are carried at MAX_W bits wide; callers pass the live width and keep the low bits.
package lfsr_pkg;

  localparam int unsigned MAX_W = 64;
  localparam int unsigned IDX_W = $clog2(MAX_W);

  typedef logic [MAX_W-1:0] lfsr_vec_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } fsm_t;

  typedef struct packed {
    lfsr_vec_t state;
    logic      out_bit;
  } step_t;

  typedef struct packed {
    lfsr_vec_t state;
    lfsr_vec_t bits;
  } adv_t;

  function automatic lfsr_vec_t width_mask(int unsigned width);
    return (width >= MAX_W) ? '1 : ((lfsr_vec_t'(1) << width) - lfsr_vec_t'(1));
  endfunction

  // One Fibonacci step: emit the MSB, shift left, feed the tap parity into bit 0.
  function automatic step_t lfsr_step(lfsr_vec_t state, lfsr_vec_t poly, int unsigned width);
    step_t r;
    r.out_bit = state[IDX_W'(width - 1)];
    r.state   = ((state << 1) | lfsr_vec_t'(^(state & poly))) & width_mask(width);
    return r;
  endfunction

  // n successive steps; the first emitted bit ends up at bits[n-1].
  function automatic adv_t lfsr_advance(lfsr_vec_t state, lfsr_vec_t poly,
                                        int unsigned width, int unsigned n);
    adv_t  r;
    step_t st;
    r.state = state;
    r.bits  = '0;
    for (int unsigned i = 0; i < n; i++) begin
      st      = lfsr_step(r.state, poly, width);
      r.state = st.state;
      r.bits  = {r.bits[MAX_W-2:0], st.out_bit};
    end
    return r;
  endfunction

endpackage

// File: rtl/lfsr_prbs_gen_advance.sv
// Purely combinational OUT_W-step unroll of the LFSR; yields the word to emit
// from the current state and the state that follows once that word is taken.
module lfsr_advance_comb
  import lfsr_pkg::*;
#(
  parameter int unsigned      WIDTH = 32,
  parameter logic [WIDTH-1:0] POLY  = WIDTH'(32'h80200003),
  parameter int unsigned      OUT_W = 1
) (
  input  logic [WIDTH-1:0] state,
  output logic [WIDTH-1:0] next_state,
  output logic [OUT_W-1:0] bits
);

  adv_t adv;
  logic unused_high_bits;

  always_comb begin
    adv = lfsr_advance(lfsr_vec_t'(state), lfsr_vec_t'(POLY), WIDTH, OUT_W);
  end

  assign next_state = adv.state[WIDTH-1:0];
  assign bits       = adv.bits[OUT_W-1:0];

  // Bits above the live widths are always zero; fold them so nothing dangles.
  assign unused_high_bits = ^(adv.state & ~width_mask(WIDTH)) ^ ^(adv.bits & ~width_mask(OUT_W));

endmodule

// File: rtl/lfsr_prbs_gen.sv
// Fibonacci LFSR PRBS source on a valid/ready stream with seed load, zero-state
// recovery, accepted-word counter and a pulse when the sequence returns to its seed.
module lfsr_prbs_gen
  import lfsr_pkg::*;
#(
  parameter int unsigned      WIDTH        = 32,
  parameter logic [WIDTH-1:0] POLY         = WIDTH'(32'h80200003),
  parameter int unsigned      OUT_W        = 1,
  parameter logic [WIDTH-1:0] DEFAULT_SEED = WIDTH'(32'h00003039),
  parameter int unsigned      CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_enable,
  input  logic [WIDTH-1:0] seed,
  input  logic             shift_enable,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] data_out,
  output logic [CNT_W-1:0] word_cnt,
  output logic             period_pulse,
  output logic             lock_err
);

  fsm_t             fsm_q, fsm_d;
  logic [WIDTH-1:0] state_q, ref_seed_q, adv_state, load_value;
  logic             hs, seed_zero;

  lfsr_advance_comb #(
    .WIDTH(WIDTH),
    .POLY (POLY),
    .OUT_W(OUT_W)
  ) u_advance (
    .state     (state_q),
    .next_state(adv_state),
    .bits      (data_out)
  );

  assign out_valid  = (fsm_q != IDLE);
  assign hs         = out_valid & out_ready;
  assign seed_zero  = (seed == '0);
  assign load_value = seed_zero ? DEFAULT_SEED : seed;

  // NOTE: next-state is assigned its hold value first so no path leaves it unassigned (no latch).
  always_comb begin
    fsm_d = fsm_q;
    unique case (fsm_q)
      IDLE:  if (shift_enable) fsm_d = RUN;
      // out_valid is 1 in RUN, so "no stall" reduces to out_ready.
      RUN:   if (!shift_enable) fsm_d = out_ready ? IDLE : DRAIN;
      DRAIN: if (hs) fsm_d = IDLE;
      default: fsm_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) fsm_q <= IDLE;
    else        fsm_q <= fsm_d;
  end

  // Load beats lock-up recovery, which beats a plain handshake advance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= DEFAULT_SEED;
      ref_seed_q   <= DEFAULT_SEED;
      word_cnt     <= '0;
      period_pulse <= 1'b0;
      lock_err     <= 1'b0;
    end else begin
      period_pulse <= 1'b0;
      lock_err     <= 1'b0;
      if (load_enable) begin
        state_q    <= load_value;
        ref_seed_q <= load_value;
        word_cnt   <= '0;
        lock_err   <= seed_zero;
      end else if (state_q == '0) begin
        state_q  <= DEFAULT_SEED;
        lock_err <= 1'b1;
        if (hs) word_cnt <= word_cnt + CNT_W'(1);
      end else if (hs) begin
        state_q      <= adv_state;
        word_cnt     <= word_cnt + CNT_W'(1);
        period_pulse <= (adv_state == ref_seed_q);
      end
    end
  end

endmodule

// File: tb/tb_lfsr_prbs_gen.sv
// Randomized and directed bench for lfsr_prbs_gen (WIDTH=4, POLY=4'hC, seed 1),
// with 1-bit and 4-bit output instances checked against a sequence-position model.
module tb_lfsr_prbs_gen;

  localparam int W  = 4;
  localparam int CW = 8;
  localparam int PERIOD = 15;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          load_enable;
  logic [W-1:0]  seed;
  logic          shift_enable;
  logic          out_ready;

  logic          v1, v4, p1, p4, l1, l4;
  logic [0:0]    d1;
  logic [3:0]    d4;
  logic [CW-1:0] c1, c4;

  lfsr_prbs_gen #(.WIDTH(W), .POLY(4'hC), .OUT_W(1), .DEFAULT_SEED(4'h1), .CNT_W(CW)) dut1 (
    .clk(clk), .rst_n(rst_n), .load_enable(load_enable), .seed(seed),
    .shift_enable(shift_enable), .out_valid(v1), .out_ready(out_ready),
    .data_out(d1), .word_cnt(c1), .period_pulse(p1), .lock_err(l1)
  );

  lfsr_prbs_gen #(.WIDTH(W), .POLY(4'hC), .OUT_W(4), .DEFAULT_SEED(4'h1), .CNT_W(CW)) dut4 (
    .clk(clk), .rst_n(rst_n), .load_enable(load_enable), .seed(seed),
    .shift_enable(shift_enable), .out_valid(v4), .out_ready(out_ready),
    .data_out(d4), .word_cnt(c4), .period_pulse(p4), .lock_err(l4)
  );

  always #5 clk = ~clk;

  // Reference: the m-sequence as a table of states/bits; each DUT is a position in it.
  int sq_state [PERIOD];
  bit sq_bit   [PERIOD];
  int m_p1, m_p4, m_ref, m_mode, m_cnt;
  bit m_pulse1, m_pulse4, m_lock;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int pos_of(int s);
    for (int i = 0; i < PERIOD; i++) if (sq_state[i] == s) return i;
    return 0;
  endfunction

  function automatic int word4(int p);
    int w = 0;
    for (int k = 0; k < 4; k++) w = (w << 1) | int'(sq_bit[(p + k) % PERIOD]);
    return w;
  endfunction

  task automatic model_reset();
    m_p1 = pos_of(1); m_p4 = m_p1; m_ref = m_p1;
    m_mode = 0; m_cnt = 0;
    m_pulse1 = 0; m_pulse4 = 0; m_lock = 0;
  endtask

  task automatic model_update();
    bit hs = (m_mode != 0) && out_ready;
    m_pulse1 = 0; m_pulse4 = 0; m_lock = 0;
    if (load_enable) begin
      m_ref  = pos_of(seed == 0 ? 1 : int'(seed));
      m_p1   = m_ref; m_p4 = m_ref;
      m_cnt  = 0;
      m_lock = (seed == 0);
    end else if (hs) begin
      m_p1     = (m_p1 + 1) % PERIOD;
      m_p4     = (m_p4 + 4) % PERIOD;
      m_cnt    = (m_cnt + 1) % (1 << CW);
      m_pulse1 = (m_p1 == m_ref);
      m_pulse4 = (m_p4 == m_ref);
    end
    case (m_mode)
      0: m_mode = shift_enable ? 1 : 0;
      1: if (!shift_enable) m_mode = out_ready ? 0 : 2;
      default: m_mode = hs ? 0 : 2;
    endcase
  endtask

  task automatic compare_all();
    check("valid1", v1, m_mode != 0);
    check("valid4", v4, m_mode != 0);
    check("data1", d1, sq_bit[m_p1]);
    check("data4", d4, word4(m_p4));
    check("cnt1", c1, m_cnt);
    check("cnt4", c4, m_cnt);
    check("pulse1", p1, m_pulse1);
    check("pulse4", p4, m_pulse4);
    check("lock1", l1, m_lock);
    check("lock4", l4, m_lock);
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
    compare_all();
  endtask

  bit         exp_bits [15] = '{0,0,0,1,0,0,1,1,0,1,0,1,1,1,1};
  logic [3:0] exp_w4   [2]  = '{4'b0001, 4'b0011};
  logic [3:0] held_d4;
  logic [0:0] held_d1;

  initial begin
    int s = 1;
    for (int i = 0; i < PERIOD; i++) begin
      sq_state[i] = s;
      sq_bit[i]   = bit'((s >> 3) & 1);
      s = ((s << 1) | (((s >> 3) ^ (s >> 2)) & 1)) & 15;
    end

    rst_n = 1'b0; load_enable = 1'b0; seed = '0; shift_enable = 1'b0; out_ready = 1'b0;
    model_reset();
    #12 rst_n = 1'b1;
    #1;
    compare_all();
    check("rst_state", d4, 4'h1);

    // Seed 1, run with ready held high for one full period.
    load_enable = 1'b1; seed = 4'h1; shift_enable = 1'b1; out_ready = 1'b1;
    tick();
    load_enable = 1'b0;
    for (int i = 0; i < 15; i++) begin
      check("t1_bit", d1, exp_bits[i]);
      if (i < 2) check("t2_word", d4, exp_w4[i]);
      tick();
    end
    check("t1_pulse", p1, 1'b1);
    check("t2_pulse", p4, 1'b1);
    check("t1_cnt", c1, 15);

    // Backpressure mid-stream.
    out_ready = 1'b0;
    held_d1 = d1; held_d4 = d4;
    repeat (5) begin
      tick();
      check("t3_hold1", d1, held_d1);
      check("t3_hold4", d4, held_d4);
      check("t3_cnt", c4, 15);
    end
    out_ready = 1'b1;
    repeat (3) tick();

    // Drop shift_enable under stall: drain one word then go idle.
    shift_enable = 1'b0; out_ready = 1'b0;
    tick();
    check("t4_drain_valid", v4, 1'b1);
    out_ready = 1'b1;
    tick();
    check("t4_idle", v4, 1'b0);
    out_ready = 1'b0;

    // Zero seed falls back to the default seed and flags lock_err for one cycle.
    load_enable = 1'b1; seed = 4'h0;
    tick();
    check("t5_lock", l4, 1'b1);
    check("t5_state", d4, 4'b0001);
    load_enable = 1'b0;
    tick();
    check("t5_lock_clr", l4, 1'b0);

    // Load wins over a same-cycle handshake.
    shift_enable = 1'b1; out_ready = 1'b1;
    repeat (3) tick();
    load_enable = 1'b1; seed = 4'h5;
    tick();
    check("t5_cnt", c4, 0);
    check("t5_word", d4, 4'b0101);
    load_enable = 1'b0;

    for (int n = 0; n < 400; n++) begin
      load_enable  = ($urandom_range(15) == 0);
      seed         = W'($urandom_range(15));
      shift_enable = ($urandom_range(3) != 0);
      out_ready    = ($urandom_range(1) != 0);
      tick();
    end

    // Asynchronous reset between edges while streaming.
    load_enable = 1'b0; shift_enable = 1'b1; out_ready = 1'b1;
    repeat (2) tick();
    #3 rst_n = 1'b0;
    #1;
    check("t6_async1", v1, 1'b0);
    check("t6_async4", v4, 1'b0);
    model_reset();
    #2 shift_enable = 1'b0; rst_n = 1'b1;
    tick();
    check("t6_idle", v4, 1'b0);
    check("t6_state", d4, 4'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
